ram_port_arbiter: RTL

RAM_PORT_ARBITER -- requirements
Module: ram_port_arbiter

---
 rtl/ram_port_arbiter_if.sv | 44 ++++
 rtl/ram_port_arbiter.sv | 76 +++++++
 2 files changed

// File: rtl/ram_port_arbiter_if.sv
// Bus bundle between two RAM requesters (A datapath, B management), the arbiter and a
// single-port synchronous RAM. The arbiter takes the slave view, the environment the master.
interface ram_port_arbiter_if #(
  parameter int C_DATA_WIDTH = 310,
  parameter int C_ADDR_WIDTH = 3
);
  logic                    a_req;
  logic                    a_wr;
  logic [C_ADDR_WIDTH-1:0] a_addr;
  logic [C_DATA_WIDTH-1:0] a_din;
  logic                    a_gnt;
  logic                    a_rvalid;

  logic                    b_req;
  logic                    b_wr;
  logic [C_ADDR_WIDTH-1:0] b_addr;
  logic [C_DATA_WIDTH-1:0] b_din;
  logic                    b_gnt;
  logic                    b_rvalid;

  logic [C_DATA_WIDTH-1:0] rd_data;

  logic                    ram_en;
  logic                    ram_wr_en;
  logic [C_ADDR_WIDTH-1:0] ram_addr;
  logic [C_DATA_WIDTH-1:0] ram_din;
  logic [C_DATA_WIDTH-1:0] ram_dout;

  modport slave (
    input  a_req, a_wr, a_addr, a_din,
    input  b_req, b_wr, b_addr, b_din,
    input  ram_dout,
    output a_gnt, a_rvalid, b_gnt, b_rvalid, rd_data,
    output ram_en, ram_wr_en, ram_addr, ram_din
  );

  modport master (
    output a_req, a_wr, a_addr, a_din,
    output b_req, b_wr, b_addr, b_din,
    output ram_dout,
    input  a_gnt, a_rvalid, b_gnt, b_rvalid, rd_data,
    input  ram_en, ram_wr_en, ram_addr, ram_din
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Two-requester arbiter for a single-port synchronous RAM: A has priority, B overrides A
// after C_STARVE_LIMIT consecutive denied cycles. Grants are combinational, rvalid registered.
module ram_port_arbiter #(
  parameter int C_DATA_WIDTH   = 310,
  parameter int C_ADDR_WIDTH   = 3,
  parameter int C_STARVE_LIMIT = 4    // legal range 1..255
) (
  input  logic                clk,
  input  logic                reset,  // synchronous, active low
  ram_port_arbiter_if.slave   bus
);

  localparam logic [7:0] STARVE_MAX = 8'(C_STARVE_LIMIT);

  logic [7:0]              starve_cnt;
  logic                    b_wins;
  logic                    a_gnt;
  logic                    b_gnt;
  logic                    a_rvalid;
  logic                    b_rvalid;
  logic                    win_wr;
  logic [C_ADDR_WIDTH-1:0] win_addr;
  logic [C_DATA_WIDTH-1:0] win_din;

  // Grants look only at the requests and starve_cnt; reset gates them off.
  always_comb begin
    b_wins = bus.b_req && (!bus.a_req || starve_cnt == STARVE_MAX);
    b_gnt  = reset && b_wins;
    a_gnt  = reset && bus.a_req && !b_wins;
  end

  always_comb begin
    // NOTE: every output of this block gets a default first so no latch is inferred.
    win_wr   = 1'b0;
    win_addr = '0;
    win_din  = '0;
    if (a_gnt) begin
      win_wr   = bus.a_wr;
      win_addr = bus.a_addr;
      win_din  = bus.a_din;
    end else if (b_gnt) begin
      win_wr   = bus.b_wr;
      win_addr = bus.b_addr;
      win_din  = bus.b_din;
    end
  end

  always_ff @(posedge clk) begin
    // NOTE: registers use non-blocking assignments so every flop samples pre-edge values.
    if (!reset) begin
      starve_cnt <= '0;
      a_rvalid   <= 1'b0;
      b_rvalid   <= 1'b0;
    end else begin
      if (!bus.b_req || b_gnt) begin
        starve_cnt <= '0;
      end else if (starve_cnt != STARVE_MAX) begin
        starve_cnt <= starve_cnt + 8'd1;
      end
      // The RAM returns read data one cycle after an enabled read edge.
      a_rvalid <= a_gnt && !bus.a_wr;
      b_rvalid <= b_gnt && !bus.b_wr;
    end
  end

  assign bus.a_gnt     = a_gnt;
  assign bus.b_gnt     = b_gnt;
  assign bus.a_rvalid  = a_rvalid;
  assign bus.b_rvalid  = b_rvalid;
  assign bus.rd_data   = bus.ram_dout;
  assign bus.ram_en    = a_gnt || b_gnt;
  assign bus.ram_wr_en = win_wr;
  assign bus.ram_addr  = win_addr;
  assign bus.ram_din   = win_din;

endmodule
